// File: rtl/swci_uart_pkg.sv
// swci_uart_pkg: UART frame constants and transmitter state encoding shared by stimulus blocks
package swci_uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
endpackage

// File: rtl/swci_sync_fifo.sv
// swci_sync_fifo: show-ahead synchronous FIFO; writes while full and reads while empty are ignored
module swci_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic push, pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push    = wr_i & ~full_o;
  assign pop     = rd_i & ~empty_o;
  assign rdata_o = mem_q[rp_q];
  always_ff @(posedge clk_i)
    if (push) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push);
      rp_q  <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/swci_uart_stim_tx.sv
// swci_uart_stim_tx: queued 8-bit UART transmitter driving the DUT receive pin
module swci_uart_stim_tx
  import swci_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       sysclk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [7:0] wdata_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       ovf_o,
  output logic       txd_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  uart_tx_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [UART_DATA_BITS-1:0] data_q, rd_data;
  logic empty, tick, last_stop, pop, txd_q, txd_d, ovf_q;
  assign tick      = cnt_q == '0;
  assign last_stop = state_q == STOP && tick && idx_q == 3'(STOP_BITS - 1);
  assign pop       = ~empty & (state_q == IDLE | last_stop);
  assign busy_o    = (state_q != IDLE) | ~empty;
  assign ovf_o     = ovf_q;
  assign txd_o     = txd_q;
  swci_sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (sysclk_i),
    .rst_i   (rst_i),
    .wr_i    (wr_i),
    .wdata_i (wdata_i),
    .rd_i    (pop),
    .rdata_o (rd_data),
    .full_o  (full_o),
    .empty_o (empty)
  );
  // Line level follows the state one cycle late so txd_o comes straight from a flop.
  always_comb
    txd_d = state_q == START  ? 1'b0 :
            state_q == DATA   ? data_q[idx_q] :
            state_q == PARITY ? ^data_q : 1'b1;
  always_ff @(posedge sysclk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      txd_q <= txd_d;
      ovf_q <= ovf_q | (wr_i & full_o);
      if (pop) begin
        data_q  <= rd_data;
        cnt_q   <= CNT_MAX;
        idx_q   <= '0;
        state_q <= START;
      end else if (state_q != IDLE) begin
        cnt_q <= tick ? CNT_MAX : cnt_q - 1'b1;
        if (tick)
          case (state_q)
            START:  state_q <= DATA;
            DATA: begin
              idx_q <= idx_q + 3'd1;
              if (idx_q == 3'd7) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: state_q <= STOP;
            STOP:   if (last_stop) state_q <= IDLE;
                    else idx_q <= idx_q + 3'd1;
            default: state_q <= IDLE;
          endcase
      end
    end
endmodule

// File: tb/tb_swci_uart_stim_tx.sv
// tb_swci_uart_stim_tx: two transmitters (8N1 and 8E2) checked by a UART receiver model and scoreboard
module tb_swci_uart_stim_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] wr, full, busy, ovf, txd;
  logic [7:0] wd [2];
  int cyc = 0, epoch = 0, n_chk = 0, n_fail = 0;
  int frames [2];
  logic [7:0] exp0 [$], exp1 [$];
  int starts0 [$], starts1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit c, input string nm, input int act, input int req);
    n_chk++;
    if (!c) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endfunction

  function automatic void push_exp(input int g, input logic [7:0] b);
    if (g == 0) exp0.push_back(b); else exp1.push_back(b);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int NSTOP = g + 1;
    int ep;
    bit ok;
    swci_uart_stim_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .PARITY_EN(g), .STOP_BITS(NSTOP)) dut (
      .sysclk_i (clk),
      .rst_i    (rst),
      .wr_i     (wr[g]),
      .wdata_i  (wd[g]),
      .full_o   (full[g]),
      .busy_o   (busy[g]),
      .ovf_o    (ovf[g]),
      .txd_o    (txd[g])
    );
    task automatic take(output logic v);
      repeat (CPB) @(negedge clk);
      v = txd[g];
      if (epoch != ep) ok = 1'b0;
    endtask
    // Receiver model: find the start edge, then sample every bit mid-cell.
    initial begin : mon
      int t0;
      logic [7:0] b, e;
      logic st, p, sp;
      logic [1:0] stp;
      frames[g] = 0;
      forever begin
        @(negedge clk);
        if (rst || txd[g]) continue;
        t0 = cyc; ep = epoch; ok = 1'b1; p = 1'b0;
        repeat (CPB/2) @(negedge clk);
        st = txd[g];
        if (epoch != ep) ok = 1'b0;
        for (int i = 0; i < 8; i++) take(b[i]);
        if (g != 0) take(p);
        stp = 2'b11;
        for (int s = 0; s < NSTOP; s++) begin
          take(sp);
          stp[s] = sp;
        end
        repeat (CPB/2 - 1) @(negedge clk);
        if (epoch != ep) ok = 1'b0;
        if (!ok) continue;
        frames[g]++;
        if (g == 0) starts0.push_back(t0); else starts1.push_back(t0);
        chk(st == 1'b0, $sformatf("u%0d_start_bit", g), int'(st), 0);
        chk(stp == 2'b11, $sformatf("u%0d_stop_bits", g), int'(stp), 3);
        chk((g == 0 ? exp0.size() : exp1.size()) != 0, $sformatf("u%0d_unexpected_frame", g), int'(b), -1);
        if ((g == 0 ? exp0.size() : exp1.size()) != 0) begin
          e = (g == 0) ? exp0.pop_front() : exp1.pop_front();
          chk(b == e, $sformatf("u%0d_data", g), int'(b), int'(e));
          if (g != 0) chk(p == ^e, "u1_parity", int'(p), int'(^e));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int g, input logic [7:0] b, input bit acc);
    wr[g] = 1'b1;
    wd[g] = b;
    if (acc) push_exp(g, b);
    step(1);
    wr[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 3000) begin
      step(1);
      n++;
    end
    chk(n < 3000, $sformatf("u%0d_idle_timeout", g), n, 3000);
    step(3 * CPB);
  endtask

  initial begin
    int f0, s, d1, d2;
    bit seen_full, line_high;
    logic [7:0] b;
    wr = '0;
    wd[0] = '0;
    wd[1] = '0;
    step(3);
    for (int g = 0; g < 2; g++) begin
      chk(txd[g] == 1'b1, "reset_txd", int'(txd[g]), 1);
      chk(full[g] == 1'b0, "reset_full", int'(full[g]), 0);
      chk(busy[g] == 1'b0, "reset_busy", int'(busy[g]), 0);
      chk(ovf[g] == 1'b0, "reset_ovf", int'(ovf[g]), 0);
    end
    rst = 1'b0;
    step(2);

    // Single 0x55: two-cycle start latency, busy spans the popped frame's 40 cycles.
    put(0, 8'h55, 1'b1);
    chk(txd[0] == 1'b1, "t1_txd_edge_n", int'(txd[0]), 1);
    step(1);
    chk(txd[0] == 1'b1, "t1_txd_edge_n1", int'(txd[0]), 1);
    step(1);
    chk(txd[0] == 1'b0, "t1_txd_falls_n2", int'(txd[0]), 0);
    step(38);
    chk(busy[0] == 1'b1, "t1_busy_n40", int'(busy[0]), 1);
    step(1);
    chk(busy[0] == 1'b0, "t1_busy_n41", int'(busy[0]), 0);
    wait_idle(0);
    chk(frames[0] == 1, "t1_frames", frames[0], 1);

    // Back-to-back frames must abut: starts exactly one frame length apart.
    s = starts0.size();
    put(0, 8'hA5, 1'b1);
    put(0, 8'h00, 1'b1);
    put(0, 8'hFF, 1'b1);
    wait_idle(0);
    d1 = (starts0.size() >= s + 3) ? starts0[s+1] - starts0[s] : -1;
    d2 = (starts0.size() >= s + 3) ? starts0[s+2] - starts0[s+1] : -1;
    chk(d1 == 40, "t2_gap_1", d1, 40);
    chk(d2 == 40, "t2_gap_2", d2, 40);

    // 8E2: 0x07 has odd weight so parity is 1; frame is 48 cycles.
    s = starts1.size();
    put(1, 8'h07, 1'b1);
    put(1, 8'h80, 1'b1);
    wait_idle(1);
    d1 = (starts1.size() >= s + 2) ? starts1[s+1] - starts1[s] : -1;
    chk(d1 == 48, "t3_frame_len", d1, 48);

    // Random bursts that never exceed the queue depth.
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 6; k++) begin
        for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
          b = 8'($urandom);
          put(g, b, 1'b1);
          step(int'($urandom_range(0, 2)));
        end
        wait_idle(g);
      end
    chk(ovf[0] == 1'b0, "rand_no_ovf0", int'(ovf[0]), 0);
    chk(ovf[1] == 1'b0, "rand_no_ovf1", int'(ovf[1]), 0);

    // Ten consecutive writes: one popped, eight queued, the tenth dropped.
    f0 = frames[0];
    seen_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr[0] = 1'b1;
      wd[0] = 8'(8'h30 + i);
      if (i < 9) push_exp(0, wd[0]);
      step(1);
      seen_full |= full[0];
    end
    wr[0] = 1'b0;
    chk(seen_full, "t4_full_seen", int'(seen_full), 1);
    chk(ovf[0] == 1'b1, "t4_ovf_set", int'(ovf[0]), 1);
    wait_idle(0);
    chk(frames[0] - f0 == 9, "t4_frames", frames[0] - f0, 9);
    chk(ovf[0] == 1'b1, "t4_ovf_sticky", int'(ovf[0]), 1);

    // Reset during data bit 3 abandons the frame and the line goes high at once.
    f0 = frames[0];
    put(0, 8'hC3, 1'b0);
    step(18);
    rst = 1'b1;
    epoch++;
    #1;
    chk(txd[0] == 1'b1, "t5_txd_async", int'(txd[0]), 1);
    chk(full[0] == 1'b0, "t5_full", int'(full[0]), 0);
    chk(busy[0] == 1'b0, "t5_busy", int'(busy[0]), 0);
    chk(ovf[0] == 1'b0, "t5_ovf_cleared", int'(ovf[0]), 0);
    step(1);
    rst = 1'b0;
    line_high = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      line_high &= txd[0] & ~busy[0];
    end
    chk(line_high, "t5_quiet_after_reset", int'(line_high), 1);
    chk(frames[0] == f0, "t5_no_frame", frames[0], f0);
    put(0, 8'h3C, 1'b1);
    wait_idle(0);
    chk(frames[0] == f0 + 1, "t5_frame_after_write", frames[0], f0 + 1);

    chk(exp0.size() == 0, "u0_pending", exp0.size(), 0);
    chk(exp1.size() == 0, "u1_pending", exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
